// File: rtl/tdc_frame_packer_if.sv
// Byte stream from the frame packer to the UART serializer (valid/ready).
interface tdc_frame_packer_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/tdc_frame_packer.sv
// Buffers TDC words in a small FIFO and emits framed bytes: A5, seq, data MSB-first.
// Define TDC_PACKER_CHECKSUM_EN to append an XOR checksum byte (seq ^ data bytes).
module tdc_frame_packer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              meas_valid,
  input  logic [DATA_W-1:0] meas_data,
  tdc_frame_packer_if.master out_if,
  output logic              busy,
  output logic [7:0]        drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NB = DATA_W / 8;
  localparam logic [2:0]  LAST = 3'(NB - 1);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

`ifdef TDC_PACKER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, SYNC, SEQ, DATA, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, SYNC, SEQ, DATA} state_t;
`endif

  state_t            state_q;
  logic              out_valid_q;
  logic [7:0]        out_data_q;
  logic [7:0]        seq_q;
  logic [DATA_W-1:0] frame_q;
  logic [2:0]        idx_q;
`ifdef TDC_PACKER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic [7:0]        drop_q;

  logic empty, full, xfer, last_w, fin, pop, wr;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FULL);
  assign xfer  = out_valid_q && out_if.out_ready;
`ifdef TDC_PACKER_CHECKSUM_EN
  assign last_w = (state_q == CSUM);
`else
  assign last_w = (state_q == DATA) && (idx_q == LAST);
`endif
  assign fin = xfer && last_w;
  // A pop frees a slot in the same cycle, so a write into a full FIFO still lands.
  assign pop = !empty && ((state_q == IDLE) || fin);
  assign wr  = meas_valid && (!full || pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({wr, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= meas_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (wr)  wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (meas_valid && !wr && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      seq_q       <= 8'h00;
      frame_q     <= '0;
      idx_q       <= '0;
`ifdef TDC_PACKER_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      case (state_q)
        IDLE: if (pop) begin
          frame_q     <= mem_q[rptr_q];
          out_data_q  <= 8'hA5;
          out_valid_q <= 1'b1;
          state_q     <= SYNC;
        end
        SYNC: if (xfer) begin
          out_data_q <= seq_q;
`ifdef TDC_PACKER_CHECKSUM_EN
          csum_q     <= seq_q;
`endif
          state_q    <= SEQ;
        end
        SEQ: if (xfer) begin
          out_data_q <= frame_q[DATA_W-1 -: 8];
`ifdef TDC_PACKER_CHECKSUM_EN
          csum_q     <= csum_q ^ frame_q[DATA_W-1 -: 8];
`endif
          frame_q    <= frame_q << 8;
          idx_q      <= '0;
          state_q    <= DATA;
        end
        DATA: if (xfer) begin
          if (idx_q != LAST) begin
            out_data_q <= frame_q[DATA_W-1 -: 8];
`ifdef TDC_PACKER_CHECKSUM_EN
            csum_q     <= csum_q ^ frame_q[DATA_W-1 -: 8];
`endif
            frame_q    <= frame_q << 8;
            idx_q      <= idx_q + 3'd1;
          end else begin
`ifdef TDC_PACKER_CHECKSUM_EN
            out_data_q <= csum_q;
            state_q    <= CSUM;
`endif
          end
        end
`ifdef TDC_PACKER_CHECKSUM_EN
        CSUM: ;
`endif
        default: state_q <= IDLE;
      endcase
      // Frame end overrides the case: chain straight into the next frame if one is queued.
      if (fin) begin
        seq_q <= seq_q + 8'd1;
        if (pop) begin
          frame_q    <= mem_q[rptr_q];
          out_data_q <= 8'hA5;
          state_q    <= SYNC;
        end else begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      end
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign busy             = (state_q != IDLE);
  assign drop_count       = drop_q;
endmodule

// File: tb/tb_tdc_frame_packer.sv
// Directed bench for tdc_frame_packer (DATA_W=16, FIFO_DEPTH=4), checksum on or off.
module tb_tdc_frame_packer;
  localparam int DATA_W = 16;
  localparam int NB     = DATA_W / 8;
`ifdef TDC_PACKER_CHECKSUM_EN
  localparam int FL = NB + 3;
`else
  localparam int FL = NB + 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              meas_valid = 1'b0;
  logic [DATA_W-1:0] meas_data = '0;
  logic              busy;
  logic [7:0]        drop_count;
  int                n_cmp = 0;
  int                n_err = 0;
  logic [15:0]       wq[$];
  int                cyc;

  tdc_frame_packer_if bus();

  tdc_frame_packer #(.DATA_W(DATA_W), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .meas_valid (meas_valid),
    .meas_data  (meas_data),
    .out_if     (bus.master),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; meas_valid = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    wq.delete();
  endtask

  task automatic push(input logic [15:0] w);
    meas_valid = 1'b1; meas_data = w;
    tick();
    meas_valid = 1'b0;
  endtask

  // Expected stream: A5, seq, hi, lo[, seq^hi^lo] per frame.
  task automatic run_frames(input int nfr, input logic [7:0] seq0, input bit toggle, output int ncyc);
    logic [7:0] exp[$];
    logic [7:0] held, s;
    logic [15:0] w;
    bit stalled;
    int k;
    for (int f = 0; f < nfr; f++) begin
      w = wq.pop_front();
      s = seq0 + 8'(f);
      exp.push_back(8'hA5); exp.push_back(s);
      exp.push_back(w[15:8]); exp.push_back(w[7:0]);
`ifdef TDC_PACKER_CHECKSUM_EN
      exp.push_back(s ^ w[15:8] ^ w[7:0]);
`endif
    end
    k = 0; ncyc = 0; stalled = 1'b0; held = 8'h00;
    while (k < exp.size() && ncyc < 2000) begin
      bus.out_ready = toggle ? (ncyc % 2 == 0) : 1'b1;
      if (stalled) chk("stall_hold", bus.out_data, held);
      if (bus.out_valid && bus.out_ready) begin
        chk($sformatf("byte%0d", k), bus.out_data, exp[k]);
        k++; stalled = 1'b0;
      end else if (bus.out_valid) begin
        held = bus.out_data; stalled = 1'b1;
      end
      tick(); ncyc++;
    end
    if (k < exp.size()) chk("frame_timeout", k, exp.size());
  endtask

  initial begin
    bus.out_ready = 1'b0;
    do_reset();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_count, 0);

    // single word, ready high; check E+1 latency
    bus.out_ready = 1'b1;
    push(16'h1234); wq.push_back(16'h1234);
    chk("lat_e0_valid", bus.out_valid, 0);
    tick();
    chk("lat_e1_valid", bus.out_valid, 1);
    chk("lat_e1_data", bus.out_data, 8'hA5);
    run_frames(1, 8'h00, 1'b0, cyc);
    chk("f1_cycles", cyc, FL);
    chk("f1_busy_after", busy, 0);
    chk("f1_valid_after", bus.out_valid, 0);

    // same word, ready toggling: seq 01, bytes held across stalls
    push(16'h1234); wq.push_back(16'h1234);
    tick();
    run_frames(1, 8'h01, 1'b1, cyc);
    chk("f2_busy_after", busy, 0);

    // overflow: 1 in frame, 4 buffered, 1 dropped; then back-to-back release
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push(16'h1000 + 16'(i));
      if (i < 5) wq.push_back(16'h1000 + 16'(i));
    end
    chk("ovf_drop", drop_count, 1);
    chk("ovf_busy", busy, 1);
    run_frames(5, 8'h00, 1'b0, cyc);
    chk("ovf_b2b_cycles", cyc, 5 * FL);
    chk("ovf_idle_after", busy, 0);

    // write into full FIFO on the same cycle as the finishing pop
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(16'h2000 + 16'(i));
      if (i > 0) wq.push_back(16'h2000 + 16'(i));
    end
    chk("full_drop0", drop_count, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < FL - 1; i++) tick();
    push(16'h2005); wq.push_back(16'h2005);
    chk("simul_pop_wr_drop", drop_count, 0);
    run_frames(5, 8'h01, 1'b0, cyc);
    chk("simul_cycles", cyc, 5 * FL);

    // drop counter saturation
    do_reset();
    for (int i = 0; i < 10; i++) push(16'(i));
    chk("drop_mid", drop_count, 5);
    for (int i = 10; i < 300; i++) push(16'(i));
    chk("drop_sat", drop_count, 255);

    // reset in the middle of the DATA phase
    do_reset();
    bus.out_ready = 1'b1;
    push(16'hCAFE);
    tick(); tick(); tick();
    chk("mid_busy", busy, 1);
    chk("mid_data", bus.out_data, 8'hCA);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", bus.out_data, 8'h00);
    rst_n = 1'b1;
    wq.delete();
    push(16'h0F0F); wq.push_back(16'h0F0F);
    tick();
    run_frames(1, 8'h00, 1'b0, cyc);
    chk("post_rst_cycles", cyc, FL);

    // 0xBEEF after reset: A5 00 BE EF (plus 51 when checksum is built in)
    do_reset();
    bus.out_ready = 1'b1;
    push(16'hBEEF); wq.push_back(16'hBEEF);
    tick();
    run_frames(1, 8'h00, 1'b0, cyc);
    chk("beef_cycles", cyc, FL);
    chk("beef_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/tdc_frame_packer.md
# tdc_frame_packer

Upstream of the UART serializer: buffers TDC measurement words in a small FIFO and breaks each into a framed byte stream (sync, sequence, data MSB-first, optional checksum) on a valid/ready byte interface that drives the serializer's `axi_valid`/`axi_ready`/`axi_data`. Measurements arrive without backpressure; words that hit a full FIFO are dropped and counted.

## Interface
- `DATA_W`, 16: measurement width in bits; multiple of 8, range 8..32.
- `FIFO_DEPTH`, 4: measurement FIFO entries; power of two, ≥2.
- `clk`  in  1: single clock, all logic on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `meas_valid`  in  1: a measurement is present this cycle; single-cycle pulse per word.
- `meas_data`  in  DATA_W: measurement word, sampled when `meas_valid`=1.
- `out_valid`  out  1: `out_data` holds a byte to transfer.
- `out_ready`  in  1: downstream accepts; transfer on the cycle with `out_valid`&&`out_ready`.
- `out_data`  out  8: frame byte.
- `busy`  out  1: frame in progress (state ≠ IDLE).
- `drop_count`  out  8: saturating count of dropped measurements.

## Operation
- FIFO write: `meas_valid`=1 and (not full, or FSM pops in the same cycle) → word stored. Otherwise the word is dropped and `drop_count` increments, saturating at 255; cleared only by reset.
- Frame: `0xA5`, `seq`, DATA_W/8 data bytes MSB-first, then `csum` if enabled. `csum` = XOR of `seq` and all data bytes (sync excluded).
- `seq`: 8-bit, starts at 0 after reset, increments by 1 (wraps 255→0) when a frame's final byte transfers.
- FSM states: IDLE, SYNC, SEQ, DATA, CSUM.
  - IDLE: FIFO non-empty → pop head into frame register, drive `0xA5`, `out_valid`=1, go SYNC.
  - SYNC: on transfer → drive `seq`, go SEQ.
  - SEQ: on transfer → drive data byte 0 (MSB), byte index=0, go DATA.
  - DATA: on transfer → if index < DATA_W/8−1 drive next byte; else go CSUM (drive `csum`) or, with checksum disabled, finish.
  - CSUM: on transfer → finish.
  - Finish: `seq`+1; FIFO non-empty → pop next word and drive `0xA5` in the same cycle (back-to-back, no gap, stay SYNC); else `out_valid`=0, go IDLE.
- `out_data` and `out_valid` are registered and held stable while `out_valid`=1 and `out_ready`=0. Downstream may sample `out_data` for many cycles after transfer; the next byte appears only after the transfer.
- `out_ready` is ignored while `out_valid`=0.
- FIFO contents are not disturbed by frame transmission; only the popped word is latched.

## Timing
- Reset values: `out_valid`=0, `out_data`=0x00, `busy`=0, `drop_count`=0, `seq`=0, FIFO empty, state IDLE.
- Latency: `meas_valid` at edge E into empty FIFO in IDLE → `out_valid`=1 with `0xA5` after edge E+1.
- One byte per transfer cycle at most; with `out_ready` tied high, a 16-bit frame with checksum is 5 consecutive cycles.
- Simultaneous pop and write when full: write accepted, count unchanged, no drop.
- Reset mid-frame: frame abandoned immediately, FIFO flushed, all outputs to reset values next cycle.

## Configuration
- `TDC_PACKER_CHECKSUM_EN` defined: CSUM state present, frame length DATA_W/8+3 bytes.
- Undefined: no CSUM state or XOR logic; frame ends after last data byte, length DATA_W/8+2 bytes.

## Test plan
- Reset, `out_ready`=1, one word 0x1234 (checksum on) → bytes A5, 00, 12, 34, 26; `busy` low after; next frame uses seq 01.
- Same word with `out_ready` toggling 1/0 every cycle → identical byte sequence; `out_data` stable across every stall cycle.
- `out_ready`=0, push 6 words with FIFO_DEPTH=4 → first popped into frame, 4 buffered, 1 dropped: `drop_count`=1; release → 5 frames back-to-back, seq 00..04, no idle gap.
- Push 300 words while `out_ready`=0 → `drop_count` saturates at 255.
- Assert `rst_n`=0 during DATA byte → next cycle `out_valid`=0, `busy`=0; fresh word afterwards framed with seq 00.
- Checksum disabled, word 0xBEEF → bytes A5, 00, BE, EF only.
